sound_tone_gen: RTL

Tone generator that sits directly downstream of the sound-control state machine. It consumes that machine's command lines (reset_sonido, fre_up, fre_down, cuente, suene) and produces a square-wave audio output, with a pitch that sweeps up or down on command. It also returns the `conto` "duration elapsed" pulse that the control machine waits on in every timed state.

---
 rtl/sound_tone_gen.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sound_tone_gen.sv
// Square-wave tone source with a saturating pitch sweep and a repeating
// duration pulse (conto) for the upstream sound-control state machine.
module sound_tone_gen #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned BASE_DIV  = 25000,
  parameter int unsigned MIN_DIV   = 5000,
  parameter int unsigned MAX_DIV   = 50000,
  parameter int unsigned STEP      = 500,
  parameter int unsigned SWEEP_DIV = 250000,
  parameter int unsigned DUR_LEN   = 5000000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             reset_sonido,
  input  logic             fre_up,
  input  logic             fre_down,
  input  logic             cuente,
  input  logic             suene,
  output logic             audio,
  output logic             conto,
  output logic [DIV_W-1:0] half_period
);

  localparam logic [DIV_W-1:0] BASE_X     = DIV_W'(BASE_DIV);
  localparam logic [DIV_W:0]   MIN_X      = (DIV_W+1)'(MIN_DIV);
  localparam logic [DIV_W:0]   MAX_X      = (DIV_W+1)'(MAX_DIV);
  localparam logic [DIV_W:0]   STEP_X     = (DIV_W+1)'(STEP);
  localparam logic [DIV_W:0]   FLOOR_X    = (DIV_W+1)'(MIN_DIV + STEP);
  localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(SWEEP_DIV - 1);
  localparam logic [CNT_W-1:0] DUR_LAST   = CNT_W'(DUR_LEN - 1);

  logic [CNT_W-1:0] sweep_q, sweep_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] tone_q, tone_d;
  logic             phase_q, phase_d;
  logic             audio_q, audio_d;
  logic             conto_q, conto_d;

  logic             tick;
  logic [DIV_W:0]   half_x, tone_x, sum_x, up_x, dn_x;

  always_comb begin
    tick    = (sweep_q == SWEEP_LAST);
    half_x  = {1'b0, half_q};
    tone_x  = {1'b0, tone_q} + (DIV_W+1)'(1);
    sum_x   = half_x + STEP_X;
    // One bit of headroom keeps both saturations exact near the limits.
    up_x    = (half_x >= FLOOR_X) ? (half_x - STEP_X) : MIN_X;
    dn_x    = (sum_x > MAX_X) ? MAX_X : sum_x;

    sweep_d = tick ? '0 : (sweep_q + CNT_W'(1));
    half_d  = half_q;
    if (tick && fre_up && !fre_down) begin
      half_d = up_x[DIV_W-1:0];
    end else if (tick && fre_down && !fre_up) begin
      half_d = dn_x[DIV_W-1:0];
    end

    tone_d  = '0;
    phase_d = 1'b0;
    if (suene) begin
      // >= rather than == so a shrinking half-period never strands the count.
      if (tone_x >= half_x) begin
        tone_d  = '0;
        phase_d = ~phase_q;
      end else begin
        tone_d  = tone_q + DIV_W'(1);
        phase_d = phase_q;
      end
    end
    audio_d = phase_q & suene;

    dur_d   = '0;
    conto_d = 1'b0;
    if (cuente) begin
      if (dur_q == DUR_LAST) begin
        conto_d = 1'b1;
      end else begin
        dur_d = dur_q + CNT_W'(1);
      end
    end

    if (reset_sonido) begin
      sweep_d = '0;
      half_d  = BASE_X;
      tone_d  = '0;
      phase_d = 1'b0;
      audio_d = 1'b0;
      dur_d   = '0;
      conto_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sweep_q <= '0;
      half_q  <= BASE_X;
      tone_q  <= '0;
      phase_q <= 1'b0;
      audio_q <= 1'b0;
      dur_q   <= '0;
      conto_q <= 1'b0;
    end else begin
      sweep_q <= sweep_d;
      half_q  <= half_d;
      tone_q  <= tone_d;
      phase_q <= phase_d;
      audio_q <= audio_d;
      dur_q   <= dur_d;
      conto_q <= conto_d;
    end
  end

  assign audio       = audio_q;
  assign conto       = conto_q;
  assign half_period = half_q;

endmodule
